axil_cmd_master: RTL and testbench

Single-outstanding AXI4-Lite master that turns a simple valid/ready command stream (read or write, address, data, strobe) into AXI4-Lite transactions and returns each transaction's response on a valid/ready response stream. It sits directly upstream of an AXI4-Lite master port. It is the block bound to the team's AXI4-Lite master formal property checker in the formal bench, so every master-side protocol rule below is mandatory, not advisory.

---
 rtl/axil_cmd_master_if.sv | 48 ++++
 rtl/axil_cmd_master.sv | 148 ++++++++++++++
 tb/tb_axil_cmd_master.sv | 356 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axil_cmd_master_if.sv
// AXI4-Lite bus bundle between a master and a slave.
// Latency: none, wires only.
// Backpressure: carries the standard per-channel valid/ready pairs unchanged.
// Ports: AW (awaddr, awprot, awvalid, awready), W (wdata, wstrb, wvalid, wready),
//        B (bresp, bvalid, bready), AR (araddr, arprot, arvalid, arready),
//        R (rdata, rresp, rvalid, rready); modports master and slave.
interface axil_cmd_master_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  logic [ADDR_WIDTH-1:0] awaddr;
  logic [2:0]            awprot;
  logic                  awvalid;
  logic                  awready;
  logic [DATA_WIDTH-1:0] wdata;
  logic [STRB_WIDTH-1:0] wstrb;
  logic                  wvalid;
  logic                  wready;
  logic [1:0]            bresp;
  logic                  bvalid;
  logic                  bready;
  logic [ADDR_WIDTH-1:0] araddr;
  logic [2:0]            arprot;
  logic                  arvalid;
  logic                  arready;
  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0]            rresp;
  logic                  rvalid;
  logic                  rready;

  modport master (
    output awaddr, awprot, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input  bresp, bvalid, output bready,
    output araddr, arprot, arvalid, input arready,
    input  rdata, rresp, rvalid, output rready
  );

  modport slave (
    input  awaddr, awprot, awvalid, output awready,
    input  wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready,
    input  araddr, arprot, arvalid, output arready,
    output rdata, rresp, rvalid, input rready
  );
endinterface

// File: rtl/axil_cmd_master.sv
// Single-outstanding AXI4-Lite master driven by a cmd stream, results on a rsp stream.
// Latency: cmd handshake at edge N -> AXI valids in N+1 -> rsp_valid in N+3 (zero-wait slave).
// Backpressure: one-entry response register; while it is full bready/rready stay low.
// Ports: clk, rst (sync, active high); cmd_* request stream; rsp_* response stream;
//        busy (not idle); m_axil AXI4-Lite master port.
module axil_cmd_master #(
  parameter int         DATA_WIDTH = 32,
  parameter int         ADDR_WIDTH = 32,
  parameter int         STRB_WIDTH = DATA_WIDTH / 8,
  parameter logic [2:0] AXI_PROT   = 3'b000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  input  logic [STRB_WIDTH-1:0] cmd_wstrb,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_write,
  output logic [1:0]            rsp_resp,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  busy,
  axil_cmd_master_if.master     m_axil
);

  typedef enum logic [2:0] {IDLE, WR_REQ, WR_RSP, RD_REQ, RD_RSP} state_t;

  state_t                state, state_d;
  logic                  aw_pend, aw_pend_d;
  logic                  w_pend, w_pend_d;
  logic                  bready_c, rready_c;
  logic                  cmd_hs, b_hs, r_hs;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [STRB_WIDTH-1:0] wstrb_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      aw_pend <= 1'b0;
      w_pend  <= 1'b0;
    end else begin
      state   <= state_d;
      aw_pend <= aw_pend_d;
      w_pend  <= w_pend_d;
    end
  end

  // awvalid/wvalid are the registered pending flags, so AXI valids never
  // depend combinationally on any input.
  always_comb begin
    state_d   = state;
    aw_pend_d = aw_pend;
    w_pend_d  = w_pend;
    cmd_ready = 1'b0;
    bready_c  = 1'b0;
    rready_c  = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = !rst;
        if (cmd_valid && !rst) begin
          if (cmd_write) begin
            state_d   = WR_REQ;
            aw_pend_d = 1'b1;
            w_pend_d  = 1'b1;
          end else begin
            state_d = RD_REQ;
          end
        end
      end
      WR_REQ: begin
        // AW and W retire independently; leave once neither is pending.
        if (m_axil.awready) aw_pend_d = 1'b0;
        if (m_axil.wready)  w_pend_d  = 1'b0;
        if (!aw_pend_d && !w_pend_d) state_d = WR_RSP;
      end
      WR_RSP: begin
        bready_c = !rsp_valid;
        if (m_axil.bvalid && !rsp_valid) state_d = IDLE;
      end
      RD_REQ: begin
        if (m_axil.arready) state_d = RD_RSP;
      end
      RD_RSP: begin
        rready_c = !rsp_valid;
        if (m_axil.rvalid && !rsp_valid) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign cmd_hs = cmd_valid && cmd_ready;
  assign b_hs   = m_axil.bvalid && bready_c;
  assign r_hs   = m_axil.rvalid && rready_c;

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
    end else if (cmd_hs) begin
      addr_q  <= cmd_addr;
      wdata_q <= cmd_wdata;
      wstrb_q <= cmd_wstrb;
    end
  end

  // bready/rready are gated by !rsp_valid, so a capture never collides with
  // an unconsumed response.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_write <= 1'b0;
      rsp_resp  <= 2'b00;
      rsp_rdata <= '0;
    end else begin
      if (rsp_valid && rsp_ready) rsp_valid <= 1'b0;
      if (b_hs) begin
        rsp_valid <= 1'b1;
        rsp_write <= 1'b1;
        rsp_resp  <= m_axil.bresp;
        rsp_rdata <= '0;
      end else if (r_hs) begin
        rsp_valid <= 1'b1;
        rsp_write <= 1'b0;
        rsp_resp  <= m_axil.rresp;
        rsp_rdata <= m_axil.rdata;
      end
    end
  end

  assign m_axil.awaddr  = addr_q;
  assign m_axil.awprot  = AXI_PROT;
  assign m_axil.awvalid = aw_pend;
  assign m_axil.wdata   = wdata_q;
  assign m_axil.wstrb   = wstrb_q;
  assign m_axil.wvalid  = w_pend;
  assign m_axil.bready  = bready_c;
  assign m_axil.araddr  = addr_q;
  assign m_axil.arprot  = AXI_PROT;
  assign m_axil.arvalid = (state == RD_REQ);
  assign m_axil.rready  = rready_c;
  assign busy           = (state != IDLE);

endmodule

// File: tb/tb_axil_cmd_master.sv
// Bench for axil_cmd_master: directed cases plus randomized traffic against a
// stalling slave model; responses are checked by a queue-based scoreboard.
module tb_axil_cmd_master;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int SW = DW / 8;

  logic clk = 1'b0;
  logic rst;
  logic rst_q = 1'b1;
  always #5 clk = ~clk;
  always @(posedge clk) rst_q <= rst;

  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic [SW-1:0] cmd_wstrb;
  logic          rsp_valid, rsp_ready, rsp_write;
  logic [1:0]    rsp_resp;
  logic [DW-1:0] rsp_rdata;
  logic          busy;

  axil_cmd_master_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  axil_cmd_master #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .STRB_WIDTH(SW), .AXI_PROT(3'b000)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_resp(rsp_resp), .rsp_rdata(rsp_rdata), .busy(busy),
    .m_axil(bus)
  );

  // What the slave must see and return for one transaction, and its stalls.
  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [1:0]  resp;
    logic [31:0] rdata;
    int          adly;
    int          wdly;
    int          bdly;
  } plan_t;

  typedef struct {
    bit          wr;
    logic [1:0]  resp;
    logic [31:0] rdata;
  } exp_t;

  plan_t plan_q[$];
  exp_t  exp_q[$];
  int    checks = 0;
  int    failures = 0;
  bit    hold = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s: got timeout expected event", name);
  endtask

  // Command driver: expected response is queued as soon as the handshake is certain.
  task automatic issue(input bit wr, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s, input logic [1:0] resp, input logic [31:0] rd,
                       input int adly, input int wdly, input int bdly);
    plan_t p;
    exp_t  e;
    int    n;
    p.wr = wr; p.addr = a; p.wdata = d; p.wstrb = s; p.resp = resp; p.rdata = rd;
    p.adly = adly; p.wdly = wdly; p.bdly = bdly;
    plan_q.push_back(p);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
    n = 0;
    while (!cmd_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) begin
      fail_now("cmd_accept");
      cmd_valid = 1'b0;
      return;
    end
    e.wr = wr; e.resp = resp; e.rdata = wr ? 32'h0 : rd;
    exp_q.push_back(e);
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_addr = $urandom; cmd_wdata = $urandom; cmd_wstrb = 4'($urandom);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((exp_q.size() != 0 || busy || rsp_valid) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) fail_now("wait_idle");
  endtask

  // Slave model: cycle-stepped at negedge, handshakes retire on the following negedge.
  initial begin : slave
    plan_t p;
    bit    act, aw_done, w_done, ar_done;
    bit    aw_hs, w_hs, ar_hs, b_hs, r_hs;
    int    ac, wc, bc, idle;
    act = 0; aw_done = 0; w_done = 0; ar_done = 0;
    aw_hs = 0; w_hs = 0; ar_hs = 0; b_hs = 0; r_hs = 0;
    ac = 0; wc = 0; bc = 0; idle = 0;
    bus.awready = 0; bus.wready = 0; bus.arready = 0;
    bus.bvalid = 0; bus.bresp = 0; bus.rvalid = 0; bus.rresp = 0; bus.rdata = 0;
    forever begin
      @(negedge clk);
      if (rst_q) begin
        act = 0; aw_done = 0; w_done = 0; ar_done = 0;
        aw_hs = 0; w_hs = 0; ar_hs = 0; b_hs = 0; r_hs = 0;
        bus.awready = 0; bus.wready = 0; bus.arready = 0; bus.bvalid = 0; bus.rvalid = 0;
      end else begin
        if (aw_hs) begin aw_done = 1; bus.awready = 0; end
        if (w_hs)  begin w_done = 1;  bus.wready = 0;  end
        if (ar_hs) begin ar_done = 1; bus.arready = 0; end
        if (b_hs)  begin bus.bvalid = 0; act = 0; end
        if (r_hs)  begin bus.rvalid = 0; act = 0; end
        if (!act && (bus.awvalid || bus.wvalid || bus.arvalid)) begin
          if (plan_q.size() == 0) begin
            fail_now("slave_plan");
          end else begin
            p = plan_q.pop_front();
            act = 1; aw_done = 0; w_done = 0; ar_done = 0;
            ac = p.adly; wc = p.wdly; bc = p.bdly; idle = 0;
            chk("txn_dir", bus.arvalid, !p.wr);
          end
        end
        if (act && p.wr) begin
          if (!aw_done && bus.awvalid && !bus.awready) begin
            if (ac == 0) begin
              chk("awaddr", bus.awaddr, p.addr);
              chk("awprot", bus.awprot, 3'b000);
              bus.awready = 1;
            end else ac--;
          end
          if (!w_done && bus.wvalid && !bus.wready) begin
            if (wc == 0) begin
              chk("wdata", bus.wdata, p.wdata);
              chk("wstrb", bus.wstrb, p.wstrb);
              bus.wready = 1;
            end else wc--;
          end
          if (aw_done && w_done && !bus.bvalid) begin
            if (bc == 0) begin bus.bvalid = 1; bus.bresp = p.resp; end
            else bc--;
          end
        end else if (act) begin
          if (!ar_done && bus.arvalid && !bus.arready) begin
            if (ac == 0) begin
              chk("araddr", bus.araddr, p.addr);
              chk("arprot", bus.arprot, 3'b000);
              bus.arready = 1;
            end else ac--;
          end
          if (ar_done && !bus.rvalid) begin
            if (bc == 0) begin bus.rvalid = 1; bus.rresp = p.resp; bus.rdata = p.rdata; end
            else bc--;
          end
        end
        if (act) begin
          idle++;
          if (idle > 400) begin fail_now("slave_stall"); act = 0; end
        end
        aw_hs = bus.awvalid && bus.awready;
        w_hs  = bus.wvalid && bus.wready;
        ar_hs = bus.arvalid && bus.arready;
        b_hs  = bus.bvalid && bus.bready;
        r_hs  = bus.rvalid && bus.rready;
      end
    end
  end

  // Response consumer and scoreboard.
  initial begin : consumer
    exp_t e;
    rsp_ready = 1'b0;
    forever begin
      @(negedge clk);
      rsp_ready = hold ? 1'b0 : ($urandom_range(0, 3) != 0);
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          fail_now("rsp_unexpected");
        end else begin
          e = exp_q.pop_front();
          chk("rsp_write", rsp_write, e.wr);
          chk("rsp_resp", rsp_resp, e.resp);
          chk("rsp_rdata", rsp_rdata, e.rdata);
        end
      end
    end
  end

  // Master-side protocol rules, checked every cycle.
  initial begin : proto
    logic        p_awv, p_awr, p_wv, p_wr, p_arv, p_arr, p_rst;
    logic [31:0] p_awaddr, p_wdata, p_araddr;
    logic [3:0]  p_wstrb;
    p_awv = 0; p_awr = 0; p_wv = 0; p_wr = 0; p_arv = 0; p_arr = 0; p_rst = 1;
    p_awaddr = 0; p_wdata = 0; p_araddr = 0; p_wstrb = 0;
    forever begin
      @(negedge clk);
      #1;
      if (!p_rst) begin
        if (p_awv && !p_awr) begin
          chk("awvalid_hold", bus.awvalid, 1'b1);
          chk("awaddr_stable", bus.awaddr, p_awaddr);
        end
        if (p_wv && !p_wr) begin
          chk("wvalid_hold", bus.wvalid, 1'b1);
          chk("wdata_stable", bus.wdata, p_wdata);
          chk("wstrb_stable", bus.wstrb, p_wstrb);
        end
        if (p_arv && !p_arr) begin
          chk("arvalid_hold", bus.arvalid, 1'b1);
          chk("araddr_stable", bus.araddr, p_araddr);
        end
      end
      chk("rd_wr_exclusive", (bus.awvalid || bus.wvalid || bus.bready) &&
                             (bus.arvalid || bus.rready), 1'b0);
      chk("rsp_backpressure", rsp_valid && (bus.bready || bus.rready), 1'b0);
      p_awv = bus.awvalid; p_awr = bus.awready; p_awaddr = bus.awaddr;
      p_wv = bus.wvalid; p_wr = bus.wready; p_wdata = bus.wdata; p_wstrb = bus.wstrb;
      p_arv = bus.arvalid; p_arr = bus.arready; p_araddr = bus.araddr;
      p_rst = rst;
    end
  end

  initial begin : watchdog
    repeat (60000) @(posedge clk);
    $display("FAIL watchdog: got timeout expected end of test");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int n;
    rst = 1'b1; cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0; cmd_wstrb = 0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_cmd_ready", cmd_ready, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_rsp_fields", {rsp_write, rsp_resp, rsp_rdata}, 35'h0);
    chk("rst_axi_ctl", {bus.awvalid, bus.wvalid, bus.arvalid, bus.bready, bus.rready}, 5'b0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_rst_cmd_ready", cmd_ready, 1'b1);
    chk("post_rst_axi_ctl", {bus.awvalid, bus.wvalid, bus.arvalid, bus.bready, bus.rready}, 5'b0);
    @(negedge clk);

    // Zero-wait write: latency profile.
    issue(1, 32'h10, 32'hDEADBEEF, 4'hF, 2'd0, 32'h0, 0, 0, 0);
    #1;
    chk("t1_valids_n1", {bus.awvalid, bus.wvalid}, 2'b11);
    @(negedge clk); #1;
    chk("t1_valids_n2", {bus.awvalid, bus.wvalid}, 2'b00);
    chk("t1_bready_n2", bus.bready, 1'b1);
    chk("t1_rsp_valid_n2", rsp_valid, 1'b0);
    @(negedge clk); #1;
    chk("t1_rsp_valid_n3", rsp_valid, 1'b1);
    chk("t1_cmd_ready_n3", cmd_ready, 1'b1);
    wait_idle();

    // W accepted at once, AW stalled 4 cycles.
    issue(1, 32'h44, 32'hCAFEF00D, 4'h5, 2'd0, 32'h0, 4, 0, 0);
    #1;
    chk("t2_wvalid_n1", bus.wvalid, 1'b1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); #1;
      chk("t2_awvalid_hold", bus.awvalid, 1'b1);
      chk("t2_awaddr", bus.awaddr, 32'h44);
      chk("t2_wvalid_low", bus.wvalid, 1'b0);
      chk("t2_bready_low", bus.bready, 1'b0);
    end
    @(negedge clk); #1;
    chk("t2_awvalid_drop", bus.awvalid, 1'b0);
    chk("t2_bready_up", bus.bready, 1'b1);
    wait_idle();

    // Read with AR stalled 5 cycles, SLVERR.
    issue(0, 32'h20, 32'h0, 4'h0, 2'd2, 32'h12345678, 5, 0, 0);
    for (int k = 0; k < 6; k++) begin
      #1;
      chk("t3_arvalid_hold", bus.arvalid, 1'b1);
      chk("t3_araddr", bus.araddr, 32'h20);
      @(negedge clk);
    end
    wait_idle();

    // Response held: second read must wait on rready.
    hold = 1'b1;
    issue(0, 32'h30, 32'h0, 4'h0, 2'd0, 32'hA5A50001, 0, 0, 0);
    n = 0;
    while (!rsp_valid && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) fail_now("t4_first_rsp");
    issue(0, 32'h34, 32'h0, 4'h0, 2'd1, 32'h5A5A0002, 0, 0, 0);
    repeat (8) begin
      @(negedge clk); #1;
      chk("t4_rready_low", bus.rready, 1'b0);
      chk("t4_rsp_held", rsp_rdata, 32'hA5A50001);
    end
    chk("t4_rvalid_waiting", bus.rvalid, 1'b1);
    hold = 1'b0;
    wait_idle();

    // Reset in WR_REQ with awvalid high.
    issue(1, 32'h50, 32'h11, 4'h1, 2'd0, 32'h0, 10, 10, 0);
    #1;
    chk("t5_awvalid_pre", bus.awvalid, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("t5_cmd_ready_in_rst", cmd_ready, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("t5_axi_ctl_after_rst", {bus.awvalid, bus.wvalid, bus.arvalid, bus.bready, bus.rready}, 5'b0);
    chk("t5_busy_after_rst", busy, 1'b0);
    chk("t5_rsp_valid_after_rst", rsp_valid, 1'b0);
    exp_q.delete();
    plan_q.delete();
    @(negedge clk);
    issue(1, 32'h54, 32'h87654321, 4'hC, 2'd3, 32'h0, 1, 2, 1);
    wait_idle();

    // Alternating then mixed random traffic with random stalls.
    for (int i = 0; i < 40; i++) begin
      bit wr;
      wr = (i < 8) ? (i % 2 == 0) : 1'($urandom_range(0, 1));
      issue(wr, $urandom, $urandom, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)),
            $urandom, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7));
    end
    wait_idle();
    chk("no_lost_rsp", exp_q.size(), 0);
    chk("all_txn_seen", plan_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
